pifo_calendar_ctrl: RTL and testbench

//  Controller for a linear array of PIFO_DEPTH calendar atoms (atom 0 = head). Converts an AXIS insert stream and an

---
 rtl/pifo_ctrl_pkg.sv | 25 ++
 rtl/pifo_ctrl_popcount.sv | 20 ++
 rtl/pifo_calendar_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pifo_calendar_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_ctrl_pkg.sv
// Shared types and helpers for the PIFO calendar controller.
package pifo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CPU_WR = 2'd1,
    ST_FLUSH  = 2'd2
  } ctrl_state_e;

  localparam int unsigned STAT_W = 32;

  // Ceiling log2, never below 1 so it is always usable as a vector width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pifo_ctrl_popcount.sv
// Combinational population count of the atoms' valid vector.
module pifo_ctrl_popcount
  import pifo_ctrl_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0]            vec_i,
  output logic [clog2(N+1)-1:0]   count_o
);

  localparam int unsigned CW = clog2(N + 1);

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      count_o = count_o + CW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/pifo_calendar_ctrl.sv
// Control for a linear PIFO calendar array: AXIS insert/pop, CPU write arbitration, flush.
// Define PIFO_CTRL_STATS_EN to enable the stat_insert/stat_pop/stat_discard counters.
module pifo_calendar_ctrl
  import pifo_ctrl_pkg::*;
#(
  parameter int unsigned ELEMENT_WIDTH       = 32,
  parameter int unsigned PIFO_DEPTH          = 16,
  parameter int unsigned PIFO_INFO_VALID_POS = 31,
  parameter int unsigned CPU_STARVE_LIMIT    = 8
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [ELEMENT_WIDTH-1:0]          s_axis_tdata,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  output logic [ELEMENT_WIDTH-1:0]          m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  input  logic                              cpu_wr_en,
  input  logic [clog2(PIFO_DEPTH)-1:0]      cpu_wr_addr,
  input  logic [ELEMENT_WIDTH-1:0]          cpu_wr_data,
  output logic                              cpu_wr_ack,
  input  logic                              cpu_flush,
  output logic                              cpu_busy,
  input  logic [ELEMENT_WIDTH-1:0]          in_pifo_head,
  input  logic [PIFO_DEPTH-1:0]             in_pifo_valid_vec,
  output logic [ELEMENT_WIDTH-1:0]          out_pifo_input,
  output logic                              out_ctl_insert,
  output logic                              out_ctl_pop,
  output logic [PIFO_DEPTH-1:0]             out_cpu_insert,
  output logic [ELEMENT_WIDTH-1:0]          out_cpu_data,
  output logic [clog2(PIFO_DEPTH+1)-1:0]    occupancy,
  output logic                              full,
  output logic                              empty,
  output logic [STAT_W-1:0]                 stat_insert,
  output logic [STAT_W-1:0]                 stat_pop,
  output logic [STAT_W-1:0]                 stat_discard
);

  localparam int unsigned AW = clog2(PIFO_DEPTH);
  localparam int unsigned OW = clog2(PIFO_DEPTH + 1);
  localparam int unsigned WW = clog2(CPU_STARVE_LIMIT + 1);

  ctrl_state_e   state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          force_stall, ins, pop, issue;

  assign full           = in_pifo_valid_vec[PIFO_DEPTH-1];
  assign empty          = ~in_pifo_valid_vec[0];
  assign m_axis_tdata   = in_pifo_head;
  assign out_pifo_input = s_axis_tdata;
  assign out_cpu_data   = cpu_wr_data;
  assign out_ctl_insert = ins;
  assign out_ctl_pop    = pop;
  assign cpu_wr_ack     = issue;
  assign occupancy      = occ_q;

  pifo_ctrl_popcount #(
    .N (PIFO_DEPTH)
  ) u_popcount (
    .vec_i   (in_pifo_valid_vec),
    .count_o (occ_d)
  );

  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    ins           = 1'b0;
    pop           = 1'b0;
    issue         = 1'b0;
    cpu_busy      = 1'b0;
    force_stall   = (state_q == ST_IDLE) && cpu_wr_en && (wait_q >= WW'(CPU_STARVE_LIMIT));
    unique case (state_q)
      ST_IDLE: begin
        s_axis_tready = ~full & ~force_stall;
        m_axis_tvalid = in_pifo_head[PIFO_INFO_VALID_POS] & ~force_stall;
        ins           = s_axis_tvalid & s_axis_tready & s_axis_tdata[PIFO_INFO_VALID_POS];
        pop           = m_axis_tvalid & m_axis_tready;
        issue         = cpu_wr_en & ~ins & ~pop & ~force_stall & ~cpu_flush;
        if (cpu_flush) begin
          state_d = ST_FLUSH;
        end else if (force_stall) begin
          state_d = ST_CPU_WR;
        end
      end
      ST_CPU_WR: begin
        issue   = cpu_wr_en & ~cpu_flush;
        state_d = cpu_flush ? ST_FLUSH : ST_IDLE;
      end
      ST_FLUSH: begin
        cpu_busy = 1'b1;
        pop      = |in_pifo_valid_vec;
        // Valid bits are contiguous from the head, so a clear atom 1 means this pop empties the array.
        if (!cpu_flush && !in_pifo_valid_vec[1]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rstn) begin
      state_d       = ST_IDLE;
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      ins           = 1'b0;
      pop           = 1'b0;
      issue         = 1'b0;
      cpu_busy      = 1'b0;
    end
  end

  always_comb begin
    out_cpu_insert = '0;
    for (int unsigned i = 0; i < PIFO_DEPTH; i++) begin
      out_cpu_insert[i] = issue && (cpu_wr_addr == AW'(i));
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (!cpu_wr_en || issue) begin
      wait_d = '0;
    end else if ((state_q == ST_IDLE) && !force_stall && (ins || pop)) begin
      wait_d = wait_q + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      occ_q   <= occ_d;
    end
  end

`ifdef PIFO_CTRL_STATS_EN
  logic [STAT_W-1:0] st_ins_q, st_pop_q, st_dis_q;
  logic              discard;

  assign discard      = s_axis_tvalid & s_axis_tready & ~s_axis_tdata[PIFO_INFO_VALID_POS];
  assign stat_insert  = st_ins_q;
  assign stat_pop     = st_pop_q;
  assign stat_discard = st_dis_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_ins_q <= '0;
      st_pop_q <= '0;
      st_dis_q <= '0;
    end else begin
      if (ins)     st_ins_q <= st_ins_q + STAT_W'(1);
      if (pop)     st_pop_q <= st_pop_q + STAT_W'(1);
      if (discard) st_dis_q <= st_dis_q + STAT_W'(1);
    end
  end
`else
  assign stat_insert  = '0;
  assign stat_pop     = '0;
  assign stat_discard = '0;
`endif

endmodule

// File: tb/tb_pifo_calendar_ctrl.sv
// Self-checking bench: emulated calendar atom array plus a rule-level reference model.
module tb_pifo_calendar_ctrl;
  localparam int D   = 4;
  localparam int EW  = 32;
  localparam int VP  = 31;
  localparam int LIM = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [EW-1:0] s_tdata, m_tdata, cpu_wr_data, in_head, out_pifo_input, out_cpu_data;
  logic          s_tvalid, s_tready, m_tvalid, m_tready;
  logic          cpu_wr_en, cpu_wr_ack, cpu_flush, cpu_busy;
  logic [1:0]    cpu_wr_addr;
  logic [D-1:0]  vvec, out_cpu_insert;
  logic          out_ctl_insert, out_ctl_pop, full, empty;
  logic [2:0]    occupancy;
  logic [31:0]   stat_insert, stat_pop, stat_discard;

  pifo_calendar_ctrl #(
    .ELEMENT_WIDTH       (EW),
    .PIFO_DEPTH          (D),
    .PIFO_INFO_VALID_POS (VP),
    .CPU_STARVE_LIMIT    (LIM)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .s_axis_tdata      (s_tdata),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (s_tready),
    .m_axis_tdata      (m_tdata),
    .m_axis_tvalid     (m_tvalid),
    .m_axis_tready     (m_tready),
    .cpu_wr_en         (cpu_wr_en),
    .cpu_wr_addr       (cpu_wr_addr),
    .cpu_wr_data       (cpu_wr_data),
    .cpu_wr_ack        (cpu_wr_ack),
    .cpu_flush         (cpu_flush),
    .cpu_busy          (cpu_busy),
    .in_pifo_head      (in_head),
    .in_pifo_valid_vec (vvec),
    .out_pifo_input    (out_pifo_input),
    .out_ctl_insert    (out_ctl_insert),
    .out_ctl_pop       (out_ctl_pop),
    .out_cpu_insert    (out_cpu_insert),
    .out_cpu_data      (out_cpu_data),
    .occupancy         (occupancy),
    .full              (full),
    .empty             (empty),
    .stat_insert       (stat_insert),
    .stat_pop          (stat_pop),
    .stat_discard      (stat_discard)
  );

  // Emulated atom array: kept sorted by rank, lowest rank at atom 0.
  logic [EW-1:0] atoms [D];
  always_comb begin
    for (int i = 0; i < D; i++) vvec[i] = atoms[i][VP];
    in_head = atoms[0];
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int r);
    return {1'b1, 31'(r)};
  endfunction

  function automatic int cnt_atoms();
    int n = 0;
    for (int i = 0; i < D; i++) if (atoms[i][VP]) n++;
    return n;
  endfunction

  task automatic atoms_apply(input logic ins, input logic pop, input logic [D-1:0] strb,
                             input logic [EW-1:0] din, input logic [EW-1:0] cdat);
    logic [EW-1:0] q[$];
    int p;
    for (int i = 0; i < D; i++) if (atoms[i][VP]) q.push_back(atoms[i]);
    if (pop && q.size() > 0) q.delete(0);
    if (ins) begin
      p = q.size();
      for (int i = 0; i < q.size(); i++) begin
        if (din[VP-1:0] < q[i][VP-1:0]) begin
          p = i;
          break;
        end
      end
      q.insert(p, din);
    end
    for (int i = 0; i < D; i++) atoms[i] = (i < q.size()) ? q[i] : '0;
    for (int i = 0; i < D; i++) if (strb[i]) atoms[i] = cdat;
  endtask

  // Reference-model state
  logic m_flushing, m_wrcyc;
  int   m_flush_left, m_starve, m_occ;
  logic [31:0] m_sins, m_spop, m_sdis;
  logic o_ack, o_busy, o_pop, o_tval;
  logic [D-1:0] o_strb;
  logic [EW-1:0] popped_q[$];

  task automatic cycle();
    int cnt;
    logic frc, e_trdy, e_tval, e_ins, e_pop, e_ack, e_busy, e_disc;
    logic [D-1:0] e_strb, one;
    logic ins_c, pop_c;
    logic [D-1:0] strb_c;
    logic [EW-1:0] s_dat_c, c_dat_c;
    one = '0;
    one[0] = 1'b1;
    #1;
    cnt = cnt_atoms();
    {frc, e_trdy, e_tval, e_ins, e_pop, e_ack, e_busy, e_disc} = '0;
    e_strb = '0;
    if (rstn) begin
      if (m_flushing) begin
        if (m_flush_left < 0) m_flush_left = (cnt > 0) ? cnt : 1;
        e_busy = 1'b1;
        e_pop  = cnt > 0;
      end else if (m_wrcyc) begin
        e_ack = cpu_wr_en && !cpu_flush;
      end else begin
        frc    = cpu_wr_en && (m_starve >= LIM);
        e_trdy = (cnt < D) && !frc;
        e_tval = (cnt > 0) && !frc;
        e_ins  = s_tvalid && e_trdy && s_tdata[VP];
        e_disc = s_tvalid && e_trdy && !s_tdata[VP];
        e_pop  = e_tval && m_tready;
        e_ack  = cpu_wr_en && !e_ins && !e_pop && !frc && !cpu_flush;
      end
      if (e_ack) e_strb = one << cpu_wr_addr;
    end
    check_eq("tready", 64'(s_tready), 64'(e_trdy));
    check_eq("tvalid", 64'(m_tvalid), 64'(e_tval));
    check_eq("tdata", 64'(m_tdata), 64'(atoms[0]));
    check_eq("ctl_insert", 64'(out_ctl_insert), 64'(e_ins));
    check_eq("ctl_pop", 64'(out_ctl_pop), 64'(e_pop));
    check_eq("cpu_strobe", 64'(out_cpu_insert), 64'(e_strb));
    check_eq("cpu_ack", 64'(cpu_wr_ack), 64'(e_ack));
    check_eq("cpu_busy", 64'(cpu_busy), 64'(e_busy));
    check_eq("occupancy", 64'(occupancy), 64'(m_occ));
    check_eq("full", 64'(full), 64'(cnt == D));
    check_eq("empty", 64'(empty), 64'(cnt == 0));
    check_eq("stat_insert", 64'(stat_insert), 64'(m_sins));
    check_eq("stat_pop", 64'(stat_pop), 64'(m_spop));
    check_eq("stat_discard", 64'(stat_discard), 64'(m_sdis));
    if (e_ins) check_eq("pifo_input", 64'(out_pifo_input), 64'(s_tdata));
    if (e_ack) check_eq("cpu_data", 64'(out_cpu_data), 64'(cpu_wr_data));
    o_ack  = cpu_wr_ack;
    o_busy = cpu_busy;
    o_pop  = out_ctl_pop;
    o_tval = m_tvalid;
    o_strb = out_cpu_insert;
    if (m_tvalid && m_tready) popped_q.push_back(m_tdata);
    ins_c   = out_ctl_insert;
    pop_c   = out_ctl_pop;
    strb_c  = out_cpu_insert;
    s_dat_c = s_tdata;
    c_dat_c = cpu_wr_data;
    @(posedge clk);
    #1;
    if (!rstn) begin
      m_flushing = 1'b0; m_wrcyc = 1'b0; m_flush_left = -1; m_starve = 0; m_occ = 0;
      m_sins = '0; m_spop = '0; m_sdis = '0;
      for (int i = 0; i < D; i++) atoms[i] = '0;
    end else begin
      m_occ = cnt;
`ifdef PIFO_CTRL_STATS_EN
      if (e_ins)  m_sins++;
      if (e_pop)  m_spop++;
      if (e_disc) m_sdis++;
`endif
      if (e_ack || !cpu_wr_en) m_starve = 0;
      else if (!m_flushing && !m_wrcyc && !frc && (e_ins || e_pop)) m_starve++;
      if (cpu_flush) begin
        m_flushing = 1'b1; m_flush_left = -1; m_wrcyc = 1'b0;
      end else if (m_flushing) begin
        m_flush_left--;
        if (m_flush_left == 0) m_flushing = 1'b0;
      end else if (m_wrcyc) begin
        m_wrcyc = 1'b0;
      end else if (frc) begin
        m_wrcyc = 1'b1;
      end
      atoms_apply(ins_c, pop_c, strb_c, s_dat_c, c_dat_c);
    end
  endtask

  task automatic push(input logic [EW-1:0] d);
    s_tvalid = 1'b1;
    s_tdata  = d;
    cycle();
    s_tvalid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int k_ack, busy_n, pop_n, j_ack;
    logic [D-1:0] strb_seen;
    rstn = 1'b0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
    cpu_wr_en = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0; cpu_flush = 1'b0;
    m_flushing = 1'b0; m_wrcyc = 1'b0; m_flush_left = -1; m_starve = 0; m_occ = 0;
    m_sins = '0; m_spop = '0; m_sdis = '0;
    for (int i = 0; i < D; i++) atoms[i] = '0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rstn = 1'b1;

    // Sorted insert/pop
    push(mk(5)); push(mk(2)); push(mk(9));
    cycle();
    check_eq("occ_three", 64'(occupancy), 64'(3));
    popped_q.delete();
    m_tready = 1'b1;
    cycle(); cycle(); cycle();
    m_tready = 1'b0;
    check_eq("pop_count", 64'(popped_q.size()), 64'(3));
    if (popped_q.size() == 3) begin
      check_eq("pop_order0", 64'(popped_q[0]), 64'(mk(2)));
      check_eq("pop_order1", 64'(popped_q[1]), 64'(mk(5)));
      check_eq("pop_order2", 64'(popped_q[2]), 64'(mk(9)));
    end
    cycle();
    check_eq("occ_zero", 64'(occupancy), 64'(0));
    check_eq("empty_after", 64'(empty), 64'(1));

    // Full back-pressure, including pop+insert in the same cycle
    push(mk(10)); push(mk(11)); push(mk(12)); push(mk(13));
    s_tvalid = 1'b1; s_tdata = mk(1);
    cycle(); cycle();
    m_tready = 1'b1;
    cycle();
    m_tready = 1'b0;
    check_eq("full_blocks_cnt", 64'(cnt_atoms()), 64'(3));
    cycle();
    s_tvalid = 1'b0;
    check_eq("insert_after_pop", 64'(atoms[0]), 64'(mk(1)));

    // Valid-bit-0 insert is accepted and dropped
    m_tready = 1'b1; cycle(); m_tready = 1'b0;
    push(32'h0000_0003);
    check_eq("discard_cnt", 64'(cnt_atoms()), 64'(3));

    // CPU write starved by continuous insert+pop traffic
    m_tready = 1'b1; cycle(); m_tready = 1'b0;
    cpu_wr_en = 1'b1; cpu_wr_addr = 2'd2; cpu_wr_data = mk(200);
    s_tvalid = 1'b1; m_tready = 1'b1;
    k_ack = -1; strb_seen = '0;
    for (int k = 0; k < 20; k++) begin
      s_tdata = mk($urandom_range(0, 99));
      cycle();
      if (o_ack) begin
        k_ack = k;
        strb_seen = o_strb;
        break;
      end
    end
    cpu_wr_en = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    check_eq("starve_ack_cycle", 64'(k_ack), 64'(9));
    check_eq("starve_strobe", 64'(strb_seen), 64'(4'b0100));
    cycle();
    check_eq("cpu_wr_landed", 64'(atoms[2]), 64'(mk(200)));

    // Flush with three valid elements and a queued CPU write
    cpu_flush = 1'b1; cpu_wr_en = 1'b1; cpu_wr_addr = 2'd0; cpu_wr_data = mk(7);
    cycle();
    cpu_flush = 1'b0;
    busy_n = 0; pop_n = 0; j_ack = -1;
    for (int j = 0; j < 12; j++) begin
      cycle();
      if (o_busy) busy_n++;
      if (o_busy && o_pop) pop_n++;
      if (o_ack) begin
        j_ack = j;
        check_eq("flush_tvalid", 64'(o_tval), 64'(0));
        break;
      end
    end
    cpu_wr_en = 1'b0;
    check_eq("flush_busy_cycles", 64'(busy_n), 64'(3));
    check_eq("flush_pops", 64'(pop_n), 64'(3));
    check_eq("flush_then_ack", 64'(j_ack), 64'(3));

    // Reset in the middle of a flush
    push(mk(20));
    cpu_flush = 1'b1; cycle(); cpu_flush = 1'b0;
    cycle();
    rstn = 1'b0;
    cycle();
    check_eq("rst_busy", 64'(cpu_busy), 64'(0));
    check_eq("rst_occ", 64'(occupancy), 64'(0));
    cycle();
    rstn = 1'b1;
    cycle();
    check_eq("post_rst_busy", 64'(o_busy), 64'(0));

    // Randomised traffic with occasional flushes
    for (int n = 0; n < 300; n++) begin
      s_tvalid  = 1'($urandom_range(0, 1));
      s_tdata   = {1'($urandom_range(0, 4) != 0), 31'($urandom_range(0, 63))};
      m_tready  = 1'($urandom_range(0, 2) != 0);
      cpu_flush = !m_flushing && ($urandom_range(0, 49) == 0);
      cycle();
    end
    s_tvalid = 1'b0; m_tready = 1'b0; cpu_flush = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
